// File: rtl/cmp_run_tracker.sv
// Match-run tracker: 2-flop sync (+ optional CMP_GLITCH_FILTER_EN filter), run FSM, 1-entry output register.
// run_valid rises 3 edges after z_in samples low; on stall the newer result is dropped and drop_flag sticks.
module cmp_run_tracker #(
  parameter int RUN_W = 8,
  parameter int CNT_W = 16
`ifdef CMP_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_in,
  input  logic             clear,
  output logic [RUN_W-1:0] run_len,
  output logic             run_valid,
  input  logic             run_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_now,
  output logic             drop_flag
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic             z_m, z_s, z_lvl;
  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [CNT_W-1:0] match_cnt_nxt;
  logic             emit;

  // Sync flops are deliberately untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_m <= 1'b0;
      z_s <= 1'b0;
    end else begin
      z_m <= z_in;
      z_s <= z_m;
    end
  end

`ifdef CMP_GLITCH_FILTER_EN
  logic       z_f;
  logic [3:0] flt_cnt;

  // Same delay on rising and falling edges keeps run length intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_f     <= 1'b0;
      flt_cnt <= 4'd0;
    end else if (z_s == z_f) begin
      flt_cnt <= 4'd0;
    end else if (flt_cnt == 4'(FILTER_LEN - 1)) begin
      z_f     <= z_s;
      flt_cnt <= 4'd0;
    end else begin
      flt_cnt <= flt_cnt + 4'd1;
    end
  end

  assign z_lvl = z_f;
`else
  assign z_lvl = z_s;
`endif

  assign match_now = z_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_cnt_nxt;
      match_cnt <= match_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    run_cnt_nxt   = run_cnt;
    match_cnt_nxt = match_cnt;
    emit          = 1'b0;
    if (clear) begin
      state_nxt     = IDLE;
      run_cnt_nxt   = '0;
      match_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (z_lvl) begin
            state_nxt     = RUN;
            run_cnt_nxt   = RUN_W'(1);
            match_cnt_nxt = match_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (z_lvl) begin
            if (run_cnt != RUN_MAX) run_cnt_nxt = run_cnt + RUN_W'(1);
          end else begin
            state_nxt = IDLE;
            emit      = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A transfer and a fresh emit in the same cycle reload without a valid gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len   <= '0;
      run_valid <= 1'b0;
      drop_flag <= 1'b0;
    end else if (clear) begin
      run_len   <= '0;
      run_valid <= 1'b0;
      drop_flag <= 1'b0;
    end else if (emit) begin
      if (!run_valid || run_ready) begin
        run_len   <= run_cnt;
        run_valid <= 1'b1;
      end else begin
        drop_flag <= 1'b1;
      end
    end else if (run_valid && run_ready) begin
      run_valid <= 1'b0;
    end
  end

endmodule
